dest_reg_scoreboard: RTL and testbench
======================================

// Module: dest_reg_scoreboard
// PURPOSE
//   Tracks outstanding register-file writes issued with the 5-bit destination selected at decode (rt/rd select).
//   Decode side issues writes; writeback side retires them.
//   Block flags read-after-write hazards on source registers and stalls issue until the producing write retires.
//   Sits between decode/issue and writeback; sole arbiter of issue stall for RAW/WAW pressure.
// PARAMETERS
//   ADDR_W   5  register address width (32 architectural registers)
//   CNT_W    2  per-register outstanding-write counter width (max 2^CNT_W-1 = 3 in flight)
//   TOT_W    7  width of total-outstanding counter (>= ADDR_W+CNT_W)
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       synchronous reset, active-low
//   issue_valid    in   1       decode presents an instruction this cycle
//   issue_wr       in   1       instruction writes a register (RegWrite)
//   issue_dest     in   ADDR_W  destination register (from rt/rd select mux)
//   src_a          in   ADDR_W  first source register (rs)
//   src_a_used     in   1       rs is read
//   src_b          in   ADDR_W  second source register (rt)
//   src_b_used     in   1       rt is read
//   wb_valid       in   1       writeback retires one register write this cycle
//   wb_dest        in   ADDR_W  register being retired
//   stall          out  1       issue not accepted this cycle (combinational)
//   busy_a         out  1       src_a has a pending write (combinational)
//   busy_b         out  1       src_b has a pending write (combinational)
//   pending_total  out  TOT_W   registered count of all outstanding writes
//   wb_err         out  1       registered 1-cycle pulse: retire of non-pending register
// BEHAVIOUR
//   State: cnt[r], CNT_W bits, r = 1..31. Register 0 is never tracked; cnt[0] reads as 0.
//   Reset (rst_n=0 at clk edge): all cnt=0, pending_total=0, wb_err=0.
//     Reset overrides issue/wb in the same cycle.
//   busy_x = src_x_used && cnt[src_x] != 0.
//   dest_full = issue_wr && issue_dest != 0 && cnt[issue_dest] == max.
//   stall = issue_valid && (busy_a || busy_b || dest_full).
//   accept = issue_valid && !stall && issue_wr && issue_dest != 0.
//   retire = wb_valid && wb_dest != 0 && cnt[wb_dest] != 0.
//   Next state, one edge after the event (latency 1):
//     - accept only: cnt[issue_dest] += 1
//     - retire only: cnt[wb_dest] -= 1
//     - accept and retire, same register: cnt unchanged
//     - accept and retire, different registers: both updates apply
//   pending_total tracks the sum of all cnt: +accept, -retire, both => unchanged.
//   wb_err <= wb_valid && wb_dest != 0 && cnt[wb_dest] == 0.
//     No counter change on error; counters never underflow and never wrap.
//   wb_valid with wb_dest = 0: ignored, no error.
//   issue_valid with !issue_wr: stall depends only on busy_a/busy_b; no state change.
//   A stalled instruction is re-presented by decode. Block holds no copy of it.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     - busy_x is suppressed when wb_valid && wb_dest == src_x && cnt[src_x] == 1,
//       i.e. writeback-to-read same-cycle forwarding is assumed.
//     - dest_full is also cleared when retire targets issue_dest.
//   WB_BYPASS_EN undefined:
//     - busy_x / dest_full use cnt only.
//     - A consumer waits one extra cycle after the final retire.
// TESTING
//   1 Reset with cnt nonzero -> next cycle all busy=0, pending_total=0, wb_err=0.
//   2 Issue wr dest=8; next cycle issue src_a=8 used -> stall=1. wb_dest=8 ->
//     stall=0 next cycle (same cycle if WB_BYPASS_EN).
//   3 Issue wr dest=5 three times, 4th issue dest=5 -> stall=1 (dest_full);
//     pending_total=3.
//   4 Same-cycle accept dest=9 and retire wb_dest=9 (cnt=1) -> cnt[9] stays 1,
//     pending_total unchanged.
//   5 wb_valid wb_dest=12 with cnt[12]=0 -> wb_err=1 for one cycle, pending_total
//     unchanged; wb_dest=0 -> wb_err=0.
//   6 Issue wr dest=0 and src_a=0 used -> stall=0, pending_total unchanged.

Source files
------------

// File: rtl/dest_reg_scoreboard.sv
// dest_reg_scoreboard: tracks outstanding register-file writes between decode
// and writeback. Each architectural register r=1..31 owns a small saturating
// in-flight counter; register 0 is never tracked and always reads as idle.
// Issue is stalled on RAW hazards (a used source still has a write in flight)
// and when the destination counter is already at its maximum.
// Optional feature macro: WB_BYPASS_EN -- assume same-cycle writeback-to-read
// forwarding, so a final retire in this cycle clears busy/dest_full immediately.
module dest_reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int TOT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] src_a,
  input  logic              src_a_used,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              src_b_used,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  output logic              stall,
  output logic              busy_a,
  output logic              busy_b,
  output logic [TOT_W-1:0]  pending_total,
  output logic              wb_err
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_dest, cnt_wb;
  logic             dest_nz, wb_nz, dest_full, accept, retire, same_reg;

  // Counter lookups; register 0 is forced idle regardless of storage.
  always_comb begin
    cnt_a    = (src_a      == '0) ? '0 : cnt_q[src_a];
    cnt_b    = (src_b      == '0) ? '0 : cnt_q[src_b];
    cnt_dest = (issue_dest == '0) ? '0 : cnt_q[issue_dest];
    cnt_wb   = (wb_dest    == '0) ? '0 : cnt_q[wb_dest];
  end

  // Hazard detection, stall and the accept/retire qualifiers.
  always_comb begin
    dest_nz  = (issue_dest != '0);
    wb_nz    = (wb_dest != '0);
    retire   = wb_valid && wb_nz && (cnt_wb != '0);
    same_reg = (wb_dest == issue_dest);
`ifdef WB_BYPASS_EN
    busy_a    = src_a_used && (cnt_a != '0) &&
                !(wb_valid && (wb_dest == src_a) && (cnt_a == CNT_ONE));
    busy_b    = src_b_used && (cnt_b != '0) &&
                !(wb_valid && (wb_dest == src_b) && (cnt_b == CNT_ONE));
    dest_full = issue_wr && dest_nz && (cnt_dest == CNT_MAX) &&
                !(retire && same_reg);
`else
    busy_a    = src_a_used && (cnt_a != '0);
    busy_b    = src_b_used && (cnt_b != '0);
    dest_full = issue_wr && dest_nz && (cnt_dest == CNT_MAX);
`endif
    stall  = issue_valid && (busy_a || busy_b || dest_full);
    accept = issue_valid && !stall && issue_wr && dest_nz;
  end

  // Next-state counters: accept and retire on the same register cancel out.
  always_comb begin
    cnt_d = cnt_q;
    tot_d = tot_q;
    err_d = wb_valid && wb_nz && (cnt_wb == '0);
    if (accept && !(retire && same_reg)) begin
      cnt_d[issue_dest] = cnt_dest + CNT_ONE;
    end
    if (retire && !(accept && same_reg)) begin
      cnt_d[wb_dest] = cnt_wb - CNT_ONE;
    end
    if (accept && !retire) begin
      tot_d = tot_q + TOT_W'(1);
    end else if (retire && !accept) begin
      tot_d = tot_q - TOT_W'(1);
    end
    cnt_d[0] = '0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  assign pending_total = tot_q;
  assign wb_err        = err_q;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb_dest_reg_scoreboard: table-driven directed vectors for dest_reg_scoreboard
// plus a hand-written saturation/drain sequence.
module tb_dest_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_wr, src_a_used, src_b_used, wb_valid;
  logic [4:0] issue_dest, src_a, src_b, wb_dest;
  logic       stall, busy_a, busy_b, wb_err;
  logic [6:0] pending_total;

  int tests = 0;
  int fails = 0;

  dest_reg_scoreboard #(.ADDR_W(5), .CNT_W(2), .TOT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
    .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .stall(stall), .busy_a(busy_a), .busy_b(busy_b),
    .pending_total(pending_total), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       iv, iwr;
    logic [4:0] idest;
    logic [4:0] sa;  logic sau;
    logic [4:0] sb;  logic sbu;
    logic       wbv; logic [4:0] wbd;
    logic       chk;
    logic       e_stall, e_ba, e_bb;
    logic [6:0] e_tot;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic iv, input logic iwr, input logic [4:0] idest,
    input logic [4:0] sa, input logic sau, input logic [4:0] sb, input logic sbu,
    input logic wbv, input logic [4:0] wbd, input logic chk,
    input logic es, input logic eba, input logic ebb, input logic [6:0] et,
    input logic ee);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.iwr = iwr; v.idest = idest;
    v.sa = sa; v.sau = sau; v.sb = sb; v.sbu = sbu;
    v.wbv = wbv; v.wbd = wbd; v.chk = chk;
    v.e_stall = es; v.e_ba = eba; v.e_bb = ebb; v.e_tot = et; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; issue_valid = v.iv; issue_wr = v.iwr; issue_dest = v.idest;
    src_a = v.sa; src_a_used = v.sau; src_b = v.sb; src_b_used = v.sbu;
    wb_valid = v.wbv; wb_dest = v.wbd;
  endtask

  // Drive one cycle of inputs, check mid-cycle, then advance past the edge.
  task automatic step(input vec_t v, input int idx);
    drive(v);
    #2;
    if (v.chk) begin
      check("stall", idx, 32'(stall), 32'(v.e_stall));
      check("busy_a", idx, 32'(busy_a), 32'(v.e_ba));
      check("busy_b", idx, 32'(busy_b), 32'(v.e_bb));
      check("pending_total", idx, 32'(pending_total), 32'(v.e_tot));
      check("wb_err", idx, 32'(wb_err), 32'(v.e_err));
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    //            rst iv wr dst sa au sb bu wv wd chk  st ba bb tot err
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    // RAW on r8, released by writeback
    tbl.push_back(mk(1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0));
`ifdef WB_BYPASS_EN
    tbl.push_back(mk(1, 1, 0, 0, 8, 1, 0, 0, 1, 8, 1,  0, 0, 0, 1, 0));
`else
    tbl.push_back(mk(1, 1, 0, 0, 8, 1, 0, 0, 1, 8, 1,  1, 1, 0, 1, 0));
`endif
    tbl.push_back(mk(1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    // Fill r5 to max, fourth issue stalls on dest_full
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 8, 1, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 1, 5, 1,  1, 0, 1, 3, 0));
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 2, 0));
    // Same-register accept+retire on r9, then different registers
    tbl.push_back(mk(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 1, 1, 9, 0, 0, 0, 0, 1, 9, 1,  0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1,  1, 1, 0, 4, 0));
    tbl.push_back(mk(1, 1, 1,10, 0, 0, 0, 0, 1, 9, 1,  0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1, 0, 0, 9, 1,10, 1, 0, 0, 1,  1, 0, 1, 4, 0));
    // Retire of idle r12 -> one-cycle error; r0 writeback ignored
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,12, 1,  0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 4, 0));
    // r0 as destination and source is never tracked
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 4, 0));
    // Reset with counters live overrides concurrent issue/writeback
    tbl.push_back(mk(0, 1, 1,11, 0, 0, 0, 0, 1, 5, 1,  0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1, 0, 0, 5, 1,10, 1, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));

    drive(tbl[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i);
    end

    // Saturate r20, drain it, then one retire too many.
    for (int k = 0; k < 3; k++) begin
      step(mk(1, 1, 1, 20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'(k), 0), 100 + k);
    end
    step(mk(1, 1, 1, 20, 20, 1, 0, 0, 0, 0, 1, 1, 1, 0, 3, 0), 103);
    for (int k = 0; k < 3; k++) begin
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 20, 1, 0, 0, 0, 7'(3 - k), 0), 104 + k);
    end
    step(mk(1, 1, 0, 0, 0, 0, 20, 1, 1, 20, 1, 0, 0, 0, 0, 0), 107);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), 108);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 109);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
